// File: rtl/load_data_aligner_pkg.sv
// Shared load-type codes, queue entry layout and alignment helper for the load data aligner.
package load_data_aligner_pkg;

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [TYPE_W-1:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_type_e;

  typedef struct packed {
    logic              valid;
    logic              filled;
    logic              kill;
    logic              ale;
    logic [TYPE_W-1:0] ty;
    logic [OFF_W-1:0]  off;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ld_entry_t;

  // Unknown type codes behave as LW, so they need a word-aligned offset.
  function automatic logic ld_misaligned(input logic [TYPE_W-1:0] ty,
                                         input logic [OFF_W-1:0]  off);
    logic mis;
    mis = 1'b0;
    case (ty)
      LD_B, LD_BU: mis = 1'b0;
      LD_H, LD_HU: mis = off[0];
      default:     mis = (off != '0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_data_aligner_extend.sv
// Combinational byte/half/word extraction and sign/zero extension of a returned load word.
module load_extend
  import load_data_aligner_pkg::*;
(
  input  logic [TYPE_W-1:0] ty_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word_i[{off_i, 3'b000} +: 8];
    half_v   = off_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = word_i;
    case (ty_i)
      LD_B:    result_o = {{24{byte_v[7]}}, byte_v};
      LD_BU:   result_o = {24'h0, byte_v};
      LD_H:    result_o = {{16{half_v[15]}}, half_v};
      LD_HU:   result_o = {16'h0, half_v};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_data_aligner.sv
// In-order outstanding-load queue between the MEM stage, the SRAM-like data port and WB.
// Optional misaligned-address trapping is enabled by defining LOAD_ALE_CHECK_EN.
module load_data_aligner
  import load_data_aligner_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [TYPE_W-1:0] req_type,
  input  logic [DEST_W-1:0] req_dest,
  output logic              mem_req,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DEST_W-1:0] rsp_dest,
  output logic              rsp_ale
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ld_entry_t        q_q [DEPTH];
  ld_entry_t        q_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  ld_entry_t        head_e;
  logic             misalign, space, issue, pop;
  logic             fill_hit;
  logic [PW-1:0]    fill_idx, fill_probe;

`ifdef LOAD_ALE_CHECK_EN
  assign misalign = ld_misaligned(req_type, req_off);
`else
  assign misalign = 1'b0;
`endif

  assign space     = resetn & ~flush & (count_q < DEPTH_C);
  assign mem_req   = req_valid & space & ~misalign;
  assign req_ready = misalign ? space : (mem_req & mem_addr_ok);
  assign issue     = req_valid & req_ready;

  assign head_e    = q_q[head_q];
  assign rsp_valid = head_e.valid & head_e.filled & ~head_e.kill;
  assign pop       = head_e.valid & head_e.filled & (head_e.kill | rsp_ready);
  assign rsp_dest  = head_e.dest;
  assign rsp_ale   = head_e.ale;

  load_extend u_extend (
    .ty_i    (head_e.ty),
    .off_i   (head_e.off),
    .word_i  (head_e.data),
    .result_o(rsp_data)
  );

  // Pre-filled (ALE) entries break the fill pointer's contiguity, so the data_ok
  // target is the first unfilled valid entry found scanning forward from fill_q.
  always_comb begin
    fill_hit   = 1'b0;
    fill_idx   = fill_q;
    fill_probe = fill_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fill_probe = fill_q + PW'(i);
      if (!fill_hit && q_q[fill_probe].valid && !q_q[fill_probe].filled) begin
        fill_hit = 1'b1;
        fill_idx = fill_probe;
      end
    end
  end

  always_comb begin
    q_d     = q_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      q_d[head_q].valid = 1'b0;
      head_d            = head_q + PW'(1);
    end

    if (mem_data_ok && fill_hit) begin
      q_d[fill_idx].filled = 1'b1;
      q_d[fill_idx].data   = mem_rdata;
      fill_d               = fill_idx + PW'(1);
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_q[i].valid) q_d[i].kill = 1'b1;
      end
    end

    if (issue) begin
      q_d[tail_q] = '{valid:  1'b1,
                      filled: misalign,
                      kill:   1'b0,
                      ale:    misalign,
                      ty:     req_type,
                      off:    req_off,
                      dest:   req_dest,
                      data:   '0};
      tail_d      = tail_q + PW'(1);
    end

    case ({issue, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_load_data_aligner.sv
// Self-checking bench for load_data_aligner: vector table plus multi-cycle corner sequences.
module tb_load_data_aligner;
  import load_data_aligner_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [1:0]  req_off;
  logic [2:0]  req_type;
  logic [4:0]  req_dest;
  logic        mem_req, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_dest;
  logic        rsp_ale;

  always #5 clk = ~clk;

  load_data_aligner #(.DEPTH(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_off    (req_off),
    .req_type   (req_type),
    .req_dest   (req_dest),
    .mem_req    (mem_req),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_dest   (rsp_dest),
    .rsp_ale    (rsp_ale)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        ale;
  } exp_t;

  typedef struct {
    logic [2:0]  ty;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] dest, input logic ale);
    exp_t e;
    e.data = d;
    e.dest = dest;
    e.ale  = ale;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_dest", 32'(rsp_dest), 32'(e.dest));
        chk("rsp_ale", 32'(rsp_ale), 32'(e.ale));
      end
    end
  end

  // Single load: issue, data_ok one cycle later, response expected the cycle after.
  task automatic do_load(input logic [2:0] ty, input logic [1:0] off, input logic [4:0] dest,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    req_valid   = 1'b1;
    req_type    = ty;
    req_off     = off;
    req_dest    = dest;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("issue_ready", 32'(req_ready), 32'd1);
    push(exp_data, dest, 1'b0);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("latency", 32'(rsp_valid), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [12];
    vt[0]  = '{LD_B,  2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
    vt[1]  = '{LD_BU, 2'd3, 32'h80FF_1234, 32'h0000_0080};
    vt[2]  = '{LD_B,  2'd0, 32'h80FF_1234, 32'h0000_0034};
    vt[3]  = '{LD_B,  2'd2, 32'h80FF_1234, 32'hFFFF_FFFF};
    vt[4]  = '{LD_BU, 2'd1, 32'h80FF_1234, 32'h0000_0012};
    vt[5]  = '{LD_H,  2'd2, 32'h8001_0000, 32'hFFFF_8001};
    vt[6]  = '{LD_HU, 2'd2, 32'h8001_0000, 32'h0000_8001};
    vt[7]  = '{LD_W,  2'd0, 32'h8001_0000, 32'h8001_0000};
    vt[8]  = '{LD_H,  2'd0, 32'h1234_ABCD, 32'hFFFF_ABCD};
    vt[9]  = '{LD_HU, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD};
    vt[10] = '{LD_HU, 2'd2, 32'h1234_ABCD, 32'h0000_1234};
    vt[11] = '{3'b110, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    resetn      = 1'b0;
    req_valid   = 1'b1;
    req_off     = '0;
    req_type    = LD_W;
    req_dest    = '0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    flush       = 1'b0;
    rsp_ready   = 1'b0;
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_dest", 32'(rsp_dest), 32'd0);
    chk("reset_rsp_ale", 32'(rsp_ale), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    req_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      do_load(vt[i].ty, vt[i].off, 5'(i + 1), vt[i].rdata, vt[i].exp);

    // Full queue with WB stalled; responses held, then delivered in order.
    rsp_ready   = 1'b0;
    req_valid   = 1'b1;
    req_type    = LD_W;
    req_off     = 2'd0;
    req_dest    = 5'd3;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("full_issue0", 32'(req_ready), 32'd1);
    push(32'h11, 5'd3, 1'b0);
    tick();
    req_dest = 5'd4;
    @(negedge clk);
    chk("full_issue1", 32'(req_ready), 32'd1);
    push(32'h22, 5'd4, 1'b0);
    tick();
    req_dest = 5'd5;
    @(negedge clk);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_mem_req", 32'(mem_req), 32'd0);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h11;
    tick();
    mem_rdata   = 32'h22;
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("stall_valid", 32'(rsp_valid), 32'd1);
    chk("stall_data", rsp_data, 32'h11);
    tick();
    @(negedge clk);
    chk("stall_hold", rsp_data, 32'h11);
    tick();
    rsp_ready = 1'b1;
    wait_drain();

    // Flush with two loads outstanding: both data_ok absorbed silently.
    req_valid = 1'b1;
    req_dest  = 5'd9;
    tick();
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush       = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hAAAA_AAAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_silent", 32'(rsp_valid), 32'd0);
      tick();
      mem_rdata = 32'hBBBB_BBBB;
      if (i == 1) mem_data_ok = 1'b0;
    end
    req_valid = 1'b1;
    req_dest  = 5'd10;
    @(negedge clk);
    chk("flush_count0", 32'(req_ready), 32'd1);
    push(32'h1111_0000, 5'd10, 1'b0);
    tick();
    req_dest = 5'd11;
    @(negedge clk);
    chk("flush_count1", 32'(req_ready), 32'd1);
    push(32'h2222_0000, 5'd11, 1'b0);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_0000;
    tick();
    mem_rdata   = 32'h2222_0000;
    tick();
    mem_data_ok = 1'b0;
    wait_drain();

    // Flush blocks a same-cycle issue; the killed entry keeps its SRAM pairing.
    req_valid = 1'b1;
    req_dest  = 5'd12;
    tick();
    flush    = 1'b1;
    req_dest = 5'd13;
    @(negedge clk);
    chk("flush_mem_req", 32'(mem_req), 32'd0);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", 32'(req_ready), 32'd1);
    push(32'hC3C3_C3C3, 5'd13, 1'b0);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5A5A_5A5A;
    tick();
    mem_rdata   = 32'hC3C3_C3C3;
    tick();
    mem_data_ok = 1'b0;
    wait_drain();

    // Misaligned word load.
    req_valid   = 1'b1;
    req_type    = LD_W;
    req_off     = 2'd1;
    req_dest    = 5'd20;
`ifdef LOAD_ALE_CHECK_EN
    mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("ale_mem_req", 32'(mem_req), 32'd0);
    chk("ale_req_ready", 32'(req_ready), 32'd1);
    push(32'd0, 5'd20, 1'b1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("ale_latency", 32'(rsp_valid), 32'd1);
    tick();
    wait_drain();
    mem_addr_ok = 1'b1;
    req_valid   = 1'b1;
    req_off     = 2'd0;
    req_dest    = 5'd21;
    push(32'h7777_7777, 5'd21, 1'b0);
    tick();
    req_type = LD_H;
    req_off  = 2'd1;
    req_dest = 5'd22;
    @(negedge clk);
    chk("ale_mix_ready", 32'(req_ready), 32'd1);
    push(32'd0, 5'd22, 1'b1);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h7777_7777;
    tick();
    mem_data_ok = 1'b0;
    wait_drain();
`else
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("noale_mem_req", 32'(mem_req), 32'd1);
    push(32'h89AB_CDEF, 5'd20, 1'b0);
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h89AB_CDEF;
    tick();
    mem_data_ok = 1'b0;
    wait_drain();
    do_load(LD_H, 2'd1, 5'd23, 32'h0000_F00D, 32'hFFFF_F00D);
`endif

    // Reset with two loads outstanding, one of them already presented.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_type  = LD_W;
    req_off   = 2'd0;
    req_dest  = 5'd5;
    tick();
    req_dest = 5'd6;
    tick();
    req_valid   = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_FEED;
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    resetn    = 1'b0;
    req_valid = 1'b1;
    req_dest  = 5'd8;
    sb.delete();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_dest", 32'(rsp_dest), 32'd0);
    chk("rst_rsp_ale", 32'(rsp_ale), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    push(32'h0BAD_F00D, 5'd8, 1'b0);
    tick();
    req_valid   = 1'b0;
    rsp_ready   = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0BAD_F00D;
    tick();
    mem_data_ok = 1'b0;
    wait_drain();

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
